// File: rtl/mmr_pkg.sv
// Shared types for the multi-mode register: operation codes and FSM states.
package mmr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_XOR  = 3'b001,
        OP_AND  = 3'b010,
        OP_LOAD = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_ADD  = 3'b110,
        OP_SUB  = 3'b111
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/multi_mode_reg_alu.sv
// Combinational update function: computes the next q and carry for one iteration.
module mmr_alu
    import mmr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] next_q,
    output logic             next_carry
);

    logic [WIDTH:0] wide;

    // Select the operation; ADD/SUB use a WIDTH+1 result so the top bit is carry/borrow.
    always_comb begin
        next_q     = q;
        next_carry = 1'b0;
        wide       = '0;
        case (op)
            OP_HOLD: next_q = q;
            OP_XOR:  next_q = q ^ a;
            OP_AND:  next_q = a & b;
            OP_LOAD: next_q = a;
            OP_SHL: begin
                next_q     = {q[WIDTH-2:0], b[0]};
                next_carry = q[WIDTH-1];
            end
            OP_SHR: begin
                next_q     = {b[0], q[WIDTH-1:1]};
                next_carry = q[0];
            end
            OP_ADD: begin
                wide       = {1'b0, q} + {1'b0, a};
                next_q     = wide[WIDTH-1:0];
                next_carry = wide[WIDTH];
            end
            OP_SUB: begin
                wide       = {1'b0, q} - {1'b0, a};
                next_q     = wide[WIDTH-1:0];
                next_carry = wide[WIDTH];
            end
            default: next_q = q;
        endcase
    end

endmodule

// File: rtl/multi_mode_reg.sv
// Iterative multi-mode register: applies a latched operation rep+1 times after start.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start; q and carry hold
//   RUN   | one update per edge until the count reaches zero or abort
module multi_mode_reg
    import mmr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CNT_W-1:0] rep,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry
);

    state_e           state, next_state;
    op_e              op_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] next_q;
    logic             next_carry;
    logic             accept;
    logic             update;

    assign busy   = (state == RUN);
    assign zero   = (q == '0);
    assign accept = (state == IDLE) && start;
    // Abort wins over the update that would otherwise happen on the same edge.
    assign update = (state == RUN) && !abort;

    mmr_alu #(.WIDTH(WIDTH)) u_alu (
        .op         (op_r),
        .q          (q),
        .a          (a_r),
        .b          (b_r),
        .next_q     (next_q),
        .next_carry (next_carry)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (abort || cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand latches, repeat counter, q/carry update and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r  <= OP_HOLD;
            a_r   <= '0;
            b_r   <= '0;
            cnt   <= '0;
            q     <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_r <= op_e'(op);
                a_r  <= a;
                b_r  <= b;
                cnt  <= rep;
            end else if (update) begin
                q     <= next_q;
                carry <= next_carry;
                if (cnt == '0) done <= 1'b1;
                else           cnt  <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multi_mode_reg.sv
// Directed testbench for multi_mode_reg; status vector is {q, busy, done, carry, zero}.
module tb_multi_mode_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [3:0] rep = 4'h0;
    logic       abort = 1'b0;
    logic [7:0] q;
    logic       busy, done, zero, carry;
    logic [11:0] st;

    int checks = 0;
    int failures = 0;

    localparam logic [2:0] HOLD = 3'b000, XOR = 3'b001, AND = 3'b010, LOAD = 3'b011;
    localparam logic [2:0] SHL = 3'b100, SHR = 3'b101, ADD = 3'b110, SUB = 3'b111;

    multi_mode_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .rep   (rep),
        .abort (abort),
        .q     (q),
        .busy  (busy),
        .done  (done),
        .zero  (zero),
        .carry (carry)
    );

    always #5 clk = ~clk;

    assign st = {q, busy, done, carry, zero};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                            input logic [3:0] r);
        start = 1'b1; op = o; a = aa; b = bb; rep = r;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (st !== {8'h00, 4'b0001}) begin failures++; $display("FAIL reset_init st=%h exp=%h", st, {8'h00, 4'b0001}); end
        rst_n = 1'b1;
        tick();
        start_op(ADD, 8'h03, 8'h00, 4'd5);
        checks++; if (st !== {8'h00, 4'b1001}) begin failures++; $display("FAIL reset_e0 st=%h exp=%h", st, {8'h00, 4'b1001}); end
        tick();
        checks++; if (st !== {8'h03, 4'b1000}) begin failures++; $display("FAIL reset_e1 st=%h exp=%h", st, {8'h03, 4'b1000}); end
        tick();
        checks++; if (st !== {8'h06, 4'b1000}) begin failures++; $display("FAIL reset_e2 st=%h exp=%h", st, {8'h06, 4'b1000}); end
        rst_n = 1'b0;
        #1;
        checks++; if (st !== {8'h00, 4'b0001}) begin failures++; $display("FAIL reset_mid st=%h exp=%h", st, {8'h00, 4'b0001}); end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (st !== {8'h00, 4'b0001}) begin failures++; $display("FAIL reset_after%0d st=%h exp=%h", i, st, {8'h00, 4'b0001}); end
        end
    endtask

    task automatic test_xor();
        start_op(XOR, 8'hA5, 8'h00, 4'd2);
        checks++; if (st !== {8'h00, 4'b1001}) begin failures++; $display("FAIL xor_e0 st=%h exp=%h", st, {8'h00, 4'b1001}); end
        tick();
        checks++; if (st !== {8'hA5, 4'b1000}) begin failures++; $display("FAIL xor_e1 st=%h exp=%h", st, {8'hA5, 4'b1000}); end
        tick();
        checks++; if (st !== {8'h00, 4'b1001}) begin failures++; $display("FAIL xor_e2 st=%h exp=%h", st, {8'h00, 4'b1001}); end
        tick();
        checks++; if (st !== {8'hA5, 4'b0100}) begin failures++; $display("FAIL xor_e3 st=%h exp=%h", st, {8'hA5, 4'b0100}); end
        tick();
        checks++; if (st !== {8'hA5, 4'b0000}) begin failures++; $display("FAIL xor_post st=%h exp=%h", st, {8'hA5, 4'b0000}); end
    endtask

    task automatic test_add_wrap();
        start_op(LOAD, 8'hF0, 8'h00, 4'd0);
        tick();
        checks++; if (st !== {8'hF0, 4'b0100}) begin failures++; $display("FAIL add_load st=%h exp=%h", st, {8'hF0, 4'b0100}); end
        start_op(ADD, 8'h08, 8'h00, 4'd2);
        tick();
        checks++; if (st !== {8'hF8, 4'b1000}) begin failures++; $display("FAIL add_e1 st=%h exp=%h", st, {8'hF8, 4'b1000}); end
        tick();
        checks++; if (st !== {8'h00, 4'b1011}) begin failures++; $display("FAIL add_e2 st=%h exp=%h", st, {8'h00, 4'b1011}); end
        tick();
        checks++; if (st !== {8'h08, 4'b0100}) begin failures++; $display("FAIL add_e3 st=%h exp=%h", st, {8'h08, 4'b0100}); end
    endtask

    task automatic test_shl();
        start_op(LOAD, 8'h81, 8'h00, 4'd0);
        tick();
        start_op(SHL, 8'h00, 8'h01, 4'd0);
        checks++; if (st !== {8'h81, 4'b1000}) begin failures++; $display("FAIL shl_e0 st=%h exp=%h", st, {8'h81, 4'b1000}); end
        tick();
        checks++; if (st !== {8'h03, 4'b0110}) begin failures++; $display("FAIL shl_e1 st=%h exp=%h", st, {8'h03, 4'b0110}); end
        tick();
        checks++; if (st !== {8'h03, 4'b0010}) begin failures++; $display("FAIL shl_carry_hold st=%h exp=%h", st, {8'h03, 4'b0010}); end
    endtask

    task automatic test_ops();
        start_op(SHR, 8'h00, 8'h01, 4'd0);
        tick();
        checks++; if (st !== {8'h81, 4'b0110}) begin failures++; $display("FAIL shr st=%h exp=%h", st, {8'h81, 4'b0110}); end
        start_op(SUB, 8'h82, 8'h00, 4'd0);
        tick();
        checks++; if (st !== {8'hFF, 4'b0110}) begin failures++; $display("FAIL sub_borrow st=%h exp=%h", st, {8'hFF, 4'b0110}); end
        start_op(AND, 8'hF0, 8'h3C, 4'd0);
        tick();
        checks++; if (st !== {8'h30, 4'b0100}) begin failures++; $display("FAIL and st=%h exp=%h", st, {8'h30, 4'b0100}); end
        start_op(HOLD, 8'hFF, 8'hFF, 4'd1);
        tick();
        checks++; if (st !== {8'h30, 4'b1000}) begin failures++; $display("FAIL hold_e1 st=%h exp=%h", st, {8'h30, 4'b1000}); end
        tick();
        checks++; if (st !== {8'h30, 4'b0100}) begin failures++; $display("FAIL hold_e2 st=%h exp=%h", st, {8'h30, 4'b0100}); end
    endtask

    task automatic test_abort();
        start_op(LOAD, 8'h03, 8'h00, 4'd0);
        tick();
        start_op(SUB, 8'h01, 8'h00, 4'd7);
        tick();
        checks++; if (st !== {8'h02, 4'b1000}) begin failures++; $display("FAIL abort_e1 st=%h exp=%h", st, {8'h02, 4'b1000}); end
        start = 1'b1; op = LOAD; a = 8'h55; rep = 4'd0;
        tick();
        start = 1'b0;
        checks++; if (st !== {8'h01, 4'b1000}) begin failures++; $display("FAIL abort_ignore st=%h exp=%h", st, {8'h01, 4'b1000}); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (st !== {8'h01, 4'b0000}) begin failures++; $display("FAIL abort_edge st=%h exp=%h", st, {8'h01, 4'b0000}); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (st !== {8'h01, 4'b0000}) begin failures++; $display("FAIL abort_after%0d st=%h exp=%h", i, st, {8'h01, 4'b0000}); end
        end
    endtask

    task automatic test_back_to_back();
        start_op(XOR, 8'h0F, 8'h00, 4'd0);
        tick();
        checks++; if (st !== {8'h0E, 4'b0100}) begin failures++; $display("FAIL b2b_first st=%h exp=%h", st, {8'h0E, 4'b0100}); end
        start_op(LOAD, 8'h3C, 8'h00, 4'd0);
        checks++; if (st !== {8'h0E, 4'b1000}) begin failures++; $display("FAIL b2b_accept st=%h exp=%h", st, {8'h0E, 4'b1000}); end
        tick();
        checks++; if (st !== {8'h3C, 4'b0100}) begin failures++; $display("FAIL b2b_second st=%h exp=%h", st, {8'h3C, 4'b0100}); end
        abort = 1'b1;
        start_op(XOR, 8'hFF, 8'h00, 4'd0);
        abort = 1'b0;
        checks++; if (st !== {8'h3C, 4'b1000}) begin failures++; $display("FAIL idle_abort_accept st=%h exp=%h", st, {8'h3C, 4'b1000}); end
        tick();
        checks++; if (st !== {8'hC3, 4'b0100}) begin failures++; $display("FAIL idle_abort_run st=%h exp=%h", st, {8'hC3, 4'b0100}); end
    endtask

    task automatic test_max_rep();
        int n;
        start_op(LOAD, 8'h00, 8'h00, 4'd0);
        tick();
        start_op(ADD, 8'h01, 8'h00, 4'd15);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n !== 16) begin failures++; $display("FAIL max_rep_updates got=%0d exp=16", n); end
        checks++; if (st !== {8'h10, 4'b0100}) begin failures++; $display("FAIL max_rep_q st=%h exp=%h", st, {8'h10, 4'b0100}); end
    endtask

    initial begin
        test_reset();
        test_xor();
        test_add_wrap();
        test_shl();
        test_ops();
        test_abort();
        test_back_to_back();
        test_max_rep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_mode_reg.md
Name: multi_mode_reg

Overview:
- Parametrised multi-bit successor to the team's single-bit mode-select flip-flop.
- A WIDTH-bit register q applies one of eight operations, selected by an op code, repeatedly for rep+1 clock cycles after a start pulse.
- Reports busy, done, zero and carry status.
- Used as a small iterative datapath element: toggle masks, shifters, repeated add/subtract.

Parameters:
- WIDTH, 8, data width of q, a and b (WIDTH >= 2)
- CNT_W, 4, width of the repeat count; max iterations 2**CNT_W

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; accepted only when busy=0
- op  input  3  operation code, latched on accept
- a  input  WIDTH  operand A, latched on accept
- b  input  WIDTH  operand B, latched on accept
- rep  input  CNT_W  repeat count; op is applied rep+1 times
- abort  input  1  synchronous cancel of a running sequence
- q  output  WIDTH  register value
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse after the final update
- zero  output  1  combinational, q == 0
- carry  output  1  status bit from the last update

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset:
  - q=0, busy=0, done=0, carry=0, FSM=IDLE, internal count=0.
  - zero therefore reads 1.
  - Reset asserted mid-sequence cancels immediately; no done pulse.
- FSM states: IDLE, RUN.
- IDLE -> RUN on the accept edge E0, i.e. start=1 and busy=0.
  - On E0: latch op, a, b; cnt <= rep; busy <= 1.
  - q is not modified on E0.
- In RUN, at each edge E1..E(rep+1): q <= f(q), carry updated, cnt decrements.
- At the edge where cnt==0 is applied:
  - state -> IDLE, busy <= 0, done <= 1 for exactly one cycle.
- Total latency: rep+2 edges from accept to done observed high.
- start while busy=1 is ignored; no queuing.
- start in the cycle done=1 (busy=0) is accepted, giving back-to-back sequences.
- abort=1 while busy=1:
  - Next edge goes to IDLE, busy <= 0, done stays 0.
  - q and carry hold; abort takes priority over that edge's update.
- abort while IDLE is ignored; a simultaneous start in IDLE is accepted.
- Operations (latched A, B; all arithmetic modulo 2**WIDTH):
  - 000 HOLD: q unchanged, carry <= 0
  - 001 XOR: q ^ A, carry <= 0
  - 010 AND: A & B, carry <= 0
  - 011 LOAD: A, carry <= 0
  - 100 SHL: {q[WIDTH-2:0], B[0]}, carry <= q[WIDTH-1]
  - 101 SHR: {B[0], q[WIDTH-1:1]}, carry <= q[0]
  - 110 ADD: q + A, carry <= carry-out of the WIDTH+1-bit sum
  - 111 SUB: q - A, carry <= borrow (1 when q < A unsigned)
- carry changes only on RUN update edges; it holds in IDLE.
- Wrap-around: ADD/SUB wrap with no saturation.
- rep = 2**CNT_W - 1 gives 2**CNT_W updates.

Decomposition:
- Shared package mmr_pkg:
  - enum op_e with the 3-bit encodings above
  - enum state_e {IDLE, RUN}
- One natural sub-module, mmr_alu: purely combinational, inputs (op, q, A, B), outputs (next_q, next_carry).
- Top holds the FSM, counter, operand latches and the q/carry/done registers.

Test Plan:
- Reset: rst_n low mid-sequence (op=ADD, rep=5, after 2 updates) -> immediately q=0, busy=0, carry=0, zero=1; no done pulse.
- XOR toggle: q=0, start op=001, a=8'hA5, rep=2 -> q=A5, 00, A5 on E1..E3; done high one cycle after E3; busy low from E3.
- ADD wrap: q=8'hF0 (LOAD first), op=110, a=8'h08, rep=2 -> q=F8, 00 (carry=1), 08 (carry=0); zero=1 only during the 00 cycle.
- SHL serial-in: q=8'h81, op=100, b[0]=1, rep=0 -> q=03, carry=1, done after a single update.
- Abort/ignore: op=111, a=1, q=3, rep=7; a second start during RUN is ignored; abort after 2 updates -> q=1 holds, busy=0 next cycle, done stays 0.
- Back-to-back: start asserted in the done cycle with op=011, a=8'h3C, rep=0 -> accepted; q=3C on the following update edge.
